// File: rtl/adc_scan_ctrl_pkg.sv
// Shared definitions for the ADC scan controller: FSM encoding, command
// word layout and the default configuration frame.
package adc_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT,
    S_XFER,
    S_GAP,
    S_DONE
  } state_t;

  localparam int FRAME_W    = 16;
  localparam int RES_W      = 12;
  localparam int CMD_CH_LSB = 12;
  localparam int CMD_CH_W   = 3;

  localparam logic [FRAME_W-1:0] DEF_CFG_WORD = 16'hA000;

  function automatic logic [FRAME_W-1:0] cmd_word(input logic [CMD_CH_W-1:0] ch);
    logic [FRAME_W-1:0] w;
    w = '0;
    w[CMD_CH_LSB +: CMD_CH_W] = ch;
    return w;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_shift16.sv
// 16-bit serial frame engine: sclk divider, fs, MSB-first command shift-out
// and result shift-in. CLK_DIV must be at least 2.
module adc_shift16 #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        sdi,
  output logic        sclk,
  output logic        fs,
  output logic        sdo,
  output logic        active,
  output logic        done,
  output logic        frame_end,
  output logic [11:0] rx_data
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   tx_sh;
  logic [15:0]   rx_sh;
  logic          div_last;
  logic          rise;
  logic          fall;

  assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
  assign rise      = active && !sclk && div_last;
  assign fall      = active &&  sclk && div_last;
  assign frame_end = fall && (bit_cnt == 4'd15);
  assign rx_data   = rx_sh[15:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk    <= 1'b0;
      fs      <= 1'b0;
      sdo     <= 1'b0;
      active  <= 1'b0;
      done    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      // one clk after the last rising sclk edge all result bits are in
      done <= active && sclk && (div_cnt == '0) && (bit_cnt == 4'd15);
      if (start) begin
        active  <= 1'b1;
        sclk    <= 1'b0;
        fs      <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        tx_sh   <= tx_word;
        sdo     <= tx_word[15];
      end else if (active) begin
        div_cnt <= div_last ? '0 : div_cnt + DW'(1);
        if (rise) begin
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[14:0], sdi};
        end
        if (fall) begin
          sclk    <= 1'b0;
          fs      <= 1'b0;
          bit_cnt <= bit_cnt + 4'd1;
          tx_sh   <= {tx_sh[14:0], 1'b0};
          sdo     <= tx_sh[14];
          if (bit_cnt == 4'd15) begin
            active <= 1'b0;
            sdo    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC scan sequencer: configuration frame, pipelined channel scan with a
// conversion gap after every frame, result strobes to the packer.
module adc_scan_ctrl
  import adc_scan_ctrl_pkg::*;
#(
  parameter int          CLK_DIV  = 8,
  parameter int          NUM_CH   = 8,
  parameter int          GAP_CYC  = 64,
  parameter logic [15:0] CFG_WORD = DEF_CFG_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        init_adc,
  input  logic        start_scan,
  output logic        cs,
  output logic        fs,
  output logic        sclk,
  output logic        sdo,
  input  logic        sdi,
  output logic        cstart,
  output logic        samp_valid,
  output logic [2:0]  samp_ch,
  output logic [11:0] samp_data,
  output logic        busy,
  output logic        scan_overrun
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t      state, nstate;
  logic [3:0]  frame_idx;
  logic [3:0]  nxt_idx;
  logic [GW-1:0] gap_cnt;
  logic        gap_last;
  logic        cfg_done;
  logic        abort;
  logic        eng_start;
  logic [15:0] tx_word;
  logic        active;
  logic        done;
  logic        frame_end;
  logic [11:0] rx_data;

  adc_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .tx_word   (tx_word),
    .sdi       (sdi),
    .sclk      (sclk),
    .fs        (fs),
    .sdo       (sdo),
    .active    (active),
    .done      (done),
    .frame_end (frame_end),
    .rx_data   (rx_data)
  );

  assign cs       = ~active;
  assign cstart   = 1'b1;
  assign busy     = (state != S_IDLE);
  assign gap_last = (gap_cnt == GW'(GAP_CYC - 1));
  assign nxt_idx  = frame_idx + 4'd1;

  always_comb begin
    nstate    = state;
    eng_start = 1'b0;
    tx_word   = cmd_word(3'd0);
    case (state)
      S_IDLE: begin
        if (init_adc) begin
          nstate    = S_CFG;
          eng_start = 1'b1;
          tx_word   = CFG_WORD;
        end else if (start_scan && ena && cfg_done) begin
          nstate    = S_XFER;
          eng_start = 1'b1;
        end
      end
      S_CFG:  if (frame_end) nstate = S_WAIT;
      S_WAIT: if (gap_last)  nstate = S_DONE;
      S_XFER: if (frame_end) nstate = S_GAP;
      S_GAP: begin
        if (gap_last) begin
          if (frame_idx == 4'(NUM_CH) || abort || !ena) begin
            nstate = S_DONE;
          end else begin
            // trailing frame re-sends channel 0 only to clock out the last result
            nstate    = S_XFER;
            eng_start = 1'b1;
            tx_word   = cmd_word((nxt_idx < 4'(NUM_CH)) ? nxt_idx[2:0] : 3'd0);
          end
        end
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      frame_idx    <= '0;
      gap_cnt      <= '0;
      cfg_done     <= 1'b0;
      abort        <= 1'b0;
      samp_valid   <= 1'b0;
      samp_ch      <= '0;
      samp_data    <= '0;
      scan_overrun <= 1'b0;
    end else begin
      state <= nstate;
      if (state == S_IDLE)                        frame_idx <= '0;
      else if (state == S_GAP && nstate == S_XFER) frame_idx <= nxt_idx;
      if ((state == S_GAP || state == S_WAIT) && !gap_last) gap_cnt <= gap_cnt + GW'(1);
      else                                                  gap_cnt <= '0;
      if (state == S_CFG && frame_end) cfg_done <= 1'b1;
      if (state == S_IDLE)                                   abort <= 1'b0;
      else if ((state == S_XFER || state == S_GAP) && !ena)  abort <= 1'b1;
      // frame k carries the result of the command sent in frame k-1
      samp_valid <= done && (state == S_XFER) && (frame_idx != 4'd0);
      if (done && state == S_XFER && frame_idx != 4'd0) begin
        samp_ch   <= 3'(frame_idx - 4'd1);
        samp_data <= rx_data;
      end
      scan_overrun <= start_scan && ((state != S_IDLE) || init_adc);
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural ADC that answers
// 12'h100+ch for the channel commanded in the previous frame.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        init_adc = 1'b0;
  logic        start_scan = 1'b0;
  logic        sdi = 1'b0;
  logic        cs, fs, sclk, sdo, cstart, samp_valid, busy, scan_overrun;
  logic [2:0]  samp_ch;
  logic [11:0] samp_data;

  int checks = 0;
  int failures = 0;

  adc_scan_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .init_adc(init_adc), .start_scan(start_scan),
    .cs(cs), .fs(fs), .sclk(sclk), .sdo(sdo), .sdi(sdi), .cstart(cstart),
    .samp_valid(samp_valid), .samp_ch(samp_ch), .samp_data(samp_data),
    .busy(busy), .scan_overrun(scan_overrun)
  );

  always #5 clk = ~clk;

  // ADC model and observers, all sampled on the falling clk edge
  logic        zero_sdi = 1'b1;
  logic [15:0] cmd_q[$];
  logic [14:0] strb_q[$];
  logic [15:0] sh = '0, cap = '0;
  logic [11:0] resp = '0;
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_sv = 1'b0;
  int cyc = 0, last_rise = 0, rise_n = 0, frames_done = 0;
  int cs_low = 0, fs_hi = 0, tbad = 0, ovr = 0;

  always @(negedge clk) begin
    cyc++;
    if (!cs && p_cs) begin
      sh = zero_sdi ? 16'h0000 : {resp, 4'h0};
      sdi = sh[15];
      rise_n = 0;
      cap = '0;
    end
    if (!cs && sclk && !p_sclk) begin
      cap = {cap[14:0], sdo};
      rise_n++;
      last_rise = cyc;
    end
    if (!cs && !sclk && p_sclk) begin
      sh = {sh[14:0], 1'b0};
      sdi = sh[15];
    end
    if (cs && !p_cs) begin
      cmd_q.push_back(cap);
      frames_done++;
      resp = 12'h100 + {9'd0, cap[14:12]};
    end
    if (!cs) cs_low++;
    if (fs) fs_hi++;
    if (samp_valid) begin
      strb_q.push_back({samp_ch, samp_data});
      if (cyc - last_rise != 2 || p_sv) tbad++;
    end
    if (scan_overrun) ovr++;
    p_cs = cs;
    p_sclk = sclk;
    p_sv = samp_valid;
  end

  task automatic clear_obs();
    cmd_q.delete();
    strb_q.delete();
    cs_low = 0; fs_hi = 0; tbad = 0; ovr = 0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL wait_idle timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start_scan = 1'b1;
    @(negedge clk) start_scan = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 1'b1)     begin failures++; $display("FAIL reset_cs got %b exp 1", cs); end
    checks++; if ({fs, sclk, sdo} !== 3'b000) begin failures++; $display("FAIL reset_fs_sclk_sdo got %b exp 000", {fs, sclk, sdo}); end
    checks++; if (cstart !== 1'b1) begin failures++; $display("FAIL reset_cstart got %b exp 1", cstart); end
    checks++; if ({samp_valid, samp_ch, samp_data} !== 16'h0) begin failures++; $display("FAIL reset_samp got %h exp 0", {samp_valid, samp_ch, samp_data}); end
    checks++; if ({busy, scan_overrun} !== 2'b00) begin failures++; $display("FAIL reset_busy_ovr got %b exp 00", {busy, scan_overrun}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan_before_cfg();
    clear_obs();
    pulse_start();
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nocfg_busy got %b exp 0", busy); end
    checks++; if (ovr != 0 || cs_low != 0) begin failures++; $display("FAIL nocfg_quiet ovr=%0d cs_low=%0d exp 0 0", ovr, cs_low); end
  endtask

  task automatic test_init_and_start();
    int n;
    zero_sdi = 1'b1;
    clear_obs();
    @(negedge clk) begin init_adc = 1'b1; start_scan = 1'b1; end
    @(negedge clk) begin init_adc = 1'b0; start_scan = 1'b0; end
    checks++; if (scan_overrun !== 1'b1) begin failures++; $display("FAIL both_overrun got %b exp 1", scan_overrun); end
    wait_idle(1000, n);
    checks++; if (cmd_q.size() != 1) begin failures++; $display("FAIL both_frames got %0d exp 1", cmd_q.size()); end
    else begin
      checks++; if (cmd_q[0] !== 16'hA000) begin failures++; $display("FAIL both_cmd got %h exp a000", cmd_q[0]); end
    end
    checks++; if (ovr != 1 || strb_q.size() != 0) begin failures++; $display("FAIL both_counts ovr=%0d strb=%0d exp 1 0", ovr, strb_q.size()); end
  endtask

  task automatic test_cfg();
    int n;
    do_reset();
    zero_sdi = 1'b1;
    clear_obs();
    @(negedge clk) init_adc = 1'b1;
    @(negedge clk) init_adc = 1'b0;
    wait_idle(1000, n);
    checks++; if (n != 321) begin failures++; $display("FAIL cfg_busy_cycles got %0d exp 321", n); end
    checks++; if (cmd_q.size() != 1) begin failures++; $display("FAIL cfg_frames got %0d exp 1", cmd_q.size()); end
    else begin
      checks++; if (cmd_q[0] !== 16'hA000) begin failures++; $display("FAIL cfg_cmd got %h exp a000", cmd_q[0]); end
    end
    checks++; if (cs_low != 256) begin failures++; $display("FAIL cfg_cs_low got %0d exp 256", cs_low); end
    checks++; if (fs_hi != 16) begin failures++; $display("FAIL cfg_fs_high got %0d exp 16", fs_hi); end
    checks++; if (strb_q.size() != 0) begin failures++; $display("FAIL cfg_strobes got %0d exp 0", strb_q.size()); end
  endtask

  task automatic check_scan(input string tag, input int nfr, input int nstb);
    logic [15:0] ec;
    logic [14:0] es;
    checks++; if (cmd_q.size() != nfr) begin failures++; $display("FAIL %s_frames got %0d exp %0d", tag, cmd_q.size(), nfr); end
    for (int i = 0; i < nfr && i < cmd_q.size(); i++) begin
      ec = (i < 8) ? {1'b0, 3'(i), 12'h000} : 16'h0000;
      checks++; if (cmd_q[i] !== ec) begin failures++; $display("FAIL %s_cmd%0d got %h exp %h", tag, i, cmd_q[i], ec); end
    end
    checks++; if (strb_q.size() != nstb) begin failures++; $display("FAIL %s_strobes got %0d exp %0d", tag, strb_q.size(), nstb); end
    for (int i = 0; i < nstb && i < strb_q.size(); i++) begin
      es = {3'(i), 12'h100 + 12'(i)};
      checks++; if (strb_q[i] !== es) begin failures++; $display("FAIL %s_strobe%0d got %h exp %h", tag, i, strb_q[i], es); end
    end
    checks++; if (tbad != 0) begin failures++; $display("FAIL %s_strobe_timing bad=%0d exp 0", tag, tbad); end
  endtask

  task automatic test_scan();
    int n;
    zero_sdi = 1'b0;
    clear_obs();
    pulse_start();
    wait_idle(4000, n);
    checks++; if (n != 2881) begin failures++; $display("FAIL scan_busy_cycles got %0d exp 2881", n); end
    check_scan("scan", 9, 8);
    checks++; if (ovr != 0) begin failures++; $display("FAIL scan_no_overrun got %0d exp 0", ovr); end
  endtask

  task automatic test_overrun();
    int n;
    clear_obs();
    pulse_start();
    repeat (100) @(negedge clk);
    start_scan = 1'b1;
    @(negedge clk) start_scan = 1'b0;
    checks++; if (scan_overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got %b exp 1", scan_overrun); end
    wait_idle(4000, n);
    checks++; if (ovr != 1) begin failures++; $display("FAIL ovr_count got %0d exp 1", ovr); end
    check_scan("ovr", 9, 8);
  endtask

  task automatic test_ena_drop();
    int n, k, fd0;
    clear_obs();
    fd0 = frames_done;
    pulse_start();
    k = 0;
    while (!(frames_done == fd0 + 3 && !cs && rise_n >= 2) && k < 5000) begin
      k++;
      @(negedge clk);
    end
    checks++; if (k >= 5000) begin failures++; $display("FAIL ena_reach_frame3 timeout frames=%0d exp %0d", frames_done - fd0, 3); end
    ena = 1'b0;
    wait_idle(2000, n);
    ena = 1'b1;
    check_scan("ena", 4, 3);
  endtask

  task automatic test_reset_mid();
    int k, fd0;
    clear_obs();
    fd0 = frames_done;
    pulse_start();
    k = 0;
    // stop once bit 7 of frame 2 has been clocked
    while (!(frames_done == fd0 + 2 && !cs && rise_n == 8) && k < 5000) begin
      k++;
      @(negedge clk);
    end
    checks++; if (k >= 5000) begin failures++; $display("FAIL rstmid_reach timeout frames=%0d exp %0d", frames_done - fd0, 2); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL rstmid_cs got %b exp 1", cs); end
    checks++; if ({fs, sclk, sdo, busy, scan_overrun, samp_valid} !== 6'b0) begin failures++; $display("FAIL rstmid_ctrl got %b exp 000000", {fs, sclk, sdo, busy, scan_overrun, samp_valid}); end
    checks++; if ({samp_ch, samp_data} !== 15'h0) begin failures++; $display("FAIL rstmid_samp got %h exp 0", {samp_ch, samp_data}); end
    @(negedge clk);
    clear_obs();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b0 || cs_low != 0) begin failures++; $display("FAIL rstmid_no_scan busy=%b cs_low=%0d exp 0 0", busy, cs_low); end
    checks++; if (strb_q.size() != 0 || ovr != 0) begin failures++; $display("FAIL rstmid_quiet strb=%0d ovr=%0d exp 0 0", strb_q.size(), ovr); end
  endtask

  initial begin
    test_reset();
    test_scan_before_cfg();
    test_init_and_start();
    test_cfg();
    test_scan();
    test_overrun();
    test_ena_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
